uart_wb: RTL and testbench
==========================

UART_WB -- requirements
Module: uart_wb

Interface
REQ-001 SHALL have parameter uart_data_width, default 32, Wishbone data width (8 when UART_DATA_BUS_WIDTH_8_EN defined).
REQ-002 SHALL have parameter uart_addr_width, default 5, Wishbone address width (3 when UART_DATA_BUS_WIDTH_8_EN defined).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port wb_adr_i, input, uart_addr_width, bus address.
REQ-006 SHALL have port wb_dat_i, input, uart_data_width, bus write data.
REQ-007 SHALL have port wb_dat_o, output, uart_data_width, bus read data.
REQ-008 SHALL have ports wb_we_i, wb_stb_i, wb_cyc_i, input, 1 each, Wishbone write-enable/strobe/cycle.
REQ-009 SHALL have port wb_sel_i, input, 4, byte-lane select.
REQ-010 SHALL have port wb_ack_o, output, 1, transfer acknowledge.
REQ-011 SHALL have port wb_adr_int, output, uart_addr_width, byte address to register file.
REQ-012 SHALL have port wb_dat8_i, output, 8, write byte to register file.
REQ-013 SHALL have port wb_dat8_o, input, 8, read byte from register file.
REQ-014 SHALL have port wb_dat32_o, input, 32, debug word from debug interface.
REQ-015 SHALL have ports we_o, re_o, output, 1 each, register-file write/read strobes.

Function
REQ-016 SHALL register wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i on every clk edge ("latched copies").
REQ-017 SHALL run ack FSM IDLE->ACK->WAIT1->WAIT2->IDLE; IDLE leaves only when wb_stb_i&wb_cyc_i sampled high; other states advance unconditionally.
REQ-018 SHALL drive wb_ack_o high exactly in ACK state: one-cycle pulse, first cycle after request sampled; max one transfer per 4 cycles.
REQ-019 SHALL assert we_o only in ACK state with latched we=1; re_o only in ACK state with latched we=0; each one cycle wide.
REQ-020 SHALL keep the FSM advancing to IDLE if stb/cyc drop mid-sequence; a request held through WAIT2 is acknowledged again.
REQ-021 32-bit mode: latched sel 0001/0010/0100/1000 selects lane 0/1/2/3 (bits 7:0/15:8/23:16/31:24); wb_adr_int = {latched adr[uart_addr_width-1:2], lane[1:0]}; wb_dat8_i = selected lane of latched data.
REQ-022 32-bit mode read: wb_dat8_o placed in selected lane, other lanes zero.
REQ-023 32-bit mode sel=1111: read returns wb_dat32_o, re_o suppressed; write ignored, we_o suppressed; wb_adr_int low bits 00.
REQ-024 Any other sel value: treated as lane 0.
REQ-025 wb_dat_o SHALL be combinational from latched sel and wb_dat8_o/wb_dat32_o, valid throughout the ACK cycle.

Reset
REQ-026 wb_rst_i low SHALL asynchronously force FSM IDLE, wb_ack_o=0, we_o=0, re_o=0, all latched copies 0 (wb_adr_int=0, wb_dat8_i=0).
REQ-027 Reset mid-transfer SHALL abort; no ack until a new request after release.

Configuration
REQ-028 Macro UART_DATA_BUS_WIDTH_8_EN defined: 8-bit bus; wb_sel_i and wb_dat32_o ignored; wb_adr_int = latched adr; wb_dat8_i = latched data; wb_dat_o = wb_dat8_o.
REQ-029 Macro undefined: 32-bit bus with lane steering per REQ-021..REQ-024; FSM/strobe timing identical in both modes.

Structure
REQ-030 Shared package uart_wb_pkg SHALL hold FSM state typedef, lane index constants, SEL_WORD=4'b1111 and default widths.
REQ-031 One sub-module uart_wb_lane_mux SHALL implement sel decode and byte steering; FSM stays in uart_wb.

Verification
REQ-032 Reset low mid-ACK -> wb_ack_o, we_o, re_o 0 immediately; wb_adr_int=0.
REQ-033 32-bit write adr=0x0C, sel=0010, dat=0x0000A500 -> one-cycle ack with we_o=1, wb_adr_int=0x0D, wb_dat8_i=0xA5.
REQ-034 32-bit read adr=0x04, sel=1000, wb_dat8_o=0x3C -> ack with re_o=1, wb_adr_int=0x07, wb_dat_o=0x3C000000.
REQ-035 32-bit read sel=1111, wb_dat32_o=0xDEADBEEF -> ack, re_o=0, wb_dat_o=0xDEADBEEF.
REQ-036 stb&cyc held high 12 cycles -> exactly 3 acks, spaced 4 cycles apart.
REQ-037 UART_DATA_BUS_WIDTH_8_EN, write adr=3, dat=0x80 -> we_o=1, wb_adr_int=3, wb_dat8_i=0x80.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg: shared definitions for the Wishbone-to-UART-register bridge.
//   - wb_state_t   : acknowledge FSM states
//   - LANE_*       : byte-lane indices within a 32-bit bus word
//   - SEL_*        : recognised byte-select patterns, SEL_WORD = whole word
//   - DEFAULT_*    : default bus widths, which depend on the build:
//       UART_DATA_BUS_WIDTH_8_EN undefined -> 32-bit data, 5-bit address
//       UART_DATA_BUS_WIDTH_8_EN defined   -> 8-bit data,  3-bit address
package uart_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_WAIT1 = 2'd2,
    ST_WAIT2 = 2'd3
  } wb_state_t;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  localparam logic [3:0] SEL_LANE_0 = 4'b0001;
  localparam logic [3:0] SEL_LANE_1 = 4'b0010;
  localparam logic [3:0] SEL_LANE_2 = 4'b0100;
  localparam logic [3:0] SEL_LANE_3 = 4'b1000;
  localparam logic [3:0] SEL_WORD   = 4'b1111;

`ifdef UART_DATA_BUS_WIDTH_8_EN
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
`else
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
`endif

endpackage

// File: rtl/uart_wb_lane_mux.sv
// uart_wb_lane_mux: byte-select decode and byte-lane steering between the
// Wishbone bus word and the 8-bit UART register file.
// Ports:
//   sel         in  latched byte-lane select
//   adr         in  latched bus address
//   dat_w       in  latched bus write data
//   dat8_rd     in  byte read from the register file
//   dat32_rd    in  debug word, returned for whole-word reads
//   adr_int     out byte address to the register file
//   dat8_wr     out byte written to the register file
//   dat_rd      out bus read data
//   word_access out high for a whole-word (debug) access
// Build option UART_DATA_BUS_WIDTH_8_EN: 8-bit bus, straight pass-through,
// sel and dat32_rd ignored.
module uart_wb_lane_mux
  import uart_wb_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int addr_width = DEFAULT_ADDR_WIDTH
) (
  input  logic [3:0]            sel,
  input  logic [addr_width-1:0] adr,
  input  logic [data_width-1:0] dat_w,
  input  logic [7:0]            dat8_rd,
  input  logic [31:0]           dat32_rd,
  output logic [addr_width-1:0] adr_int,
  output logic [7:0]            dat8_wr,
  output logic [data_width-1:0] dat_rd,
  output logic                  word_access
);

`ifdef UART_DATA_BUS_WIDTH_8_EN

  // The 8-bit bus maps one-to-one onto the register file.
  assign adr_int     = adr;
  assign dat8_wr     = dat_w[7:0];
  assign dat_rd      = data_width'(dat8_rd);
  assign word_access = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{sel, dat32_rd, dat_w};

`else

  logic [1:0] lane;

  // Single-lane selects pick their lane; the full-word select is the debug
  // access and reuses lane 0 so the register address ends in 00. Any
  // malformed select also falls back to lane 0.
  always_comb begin
    lane        = LANE_0;
    word_access = 1'b0;
    case (sel)
      SEL_LANE_0: lane = LANE_0;
      SEL_LANE_1: lane = LANE_1;
      SEL_LANE_2: lane = LANE_2;
      SEL_LANE_3: lane = LANE_3;
      SEL_WORD:   word_access = 1'b1;
      default:    lane = LANE_0;
    endcase
  end

  // The lane index replaces the word-aligned address bits.
  assign adr_int = {adr[addr_width-1:2], lane};
  assign dat8_wr = dat_w[{lane, 3'b000} +: 8];

  // Read data lands in the selected lane with the other lanes cleared.
  always_comb begin
    dat_rd = '0;
    if (word_access) begin
      dat_rd = data_width'(dat32_rd);
    end else begin
      dat_rd[{lane, 3'b000} +: 8] = dat8_rd;
    end
  end

  logic unused_adr;
  assign unused_adr = ^adr[1:0];

`endif

endmodule

// File: rtl/uart_wb.sv
// uart_wb: Wishbone slave front end for the UART register file.
// Every request is acknowledged with a one-cycle pulse the cycle after it
// is sampled; the FSM then idles for two cycles, so at most one transfer
// completes every four cycles.
// Ports:
//   clk, wb_rst_i (async, active-low)
//   wb_adr_i, wb_dat_i, wb_dat_o, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
//   wb_ack_o          Wishbone slave side
//   wb_adr_int, wb_dat8_i, wb_dat8_o, we_o, re_o   register-file side
//   wb_dat32_o        debug word returned for whole-word reads
// Build option UART_DATA_BUS_WIDTH_8_EN selects the 8-bit bus variant.
module uart_wb
  import uart_wb_pkg::*;
#(
  parameter int uart_data_width = DEFAULT_DATA_WIDTH,
  parameter int uart_addr_width = DEFAULT_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       wb_rst_i,
  input  logic [uart_addr_width-1:0] wb_adr_i,
  input  logic [uart_data_width-1:0] wb_dat_i,
  output logic [uart_data_width-1:0] wb_dat_o,
  input  logic                       wb_we_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_cyc_i,
  input  logic [3:0]                 wb_sel_i,
  output logic                       wb_ack_o,
  output logic [uart_addr_width-1:0] wb_adr_int,
  output logic [7:0]                 wb_dat8_i,
  input  logic [7:0]                 wb_dat8_o,
  input  logic [31:0]                wb_dat32_o,
  output logic                       we_o,
  output logic                       re_o
);

  wb_state_t                  state;
  logic                       ack_q;
  logic [uart_addr_width-1:0] adr_q;
  logic [uart_data_width-1:0] dat_q;
  logic [3:0]                 sel_q;
  logic                       we_q;
  logic                       stb_q;
  logic                       cyc_q;
  logic                       word_access;

  // Latched copies of the bus inputs, refreshed every cycle. They line up
  // with the ACK state because the FSM samples the same edge.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      stb_q <= 1'b0;
      cyc_q <= 1'b0;
    end else begin
      adr_q <= wb_adr_i;
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
      we_q  <= wb_we_i;
      stb_q <= wb_stb_i;
      cyc_q <= wb_cyc_i;
    end
  end

  // Acknowledge FSM. Only IDLE waits on the bus; the other states step on
  // unconditionally, so a request still held in WAIT2 is taken again.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_stb_i && wb_cyc_i) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
          end
        end
        ST_ACK:   state <= ST_WAIT1;
        ST_WAIT1: state <= ST_WAIT2;
        ST_WAIT2: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Register-file strobes ride on the ack pulse; whole-word accesses target
  // the debug word only and never touch the register file.
  assign wb_ack_o = ack_q;
  assign we_o     = ack_q & stb_q & cyc_q & we_q & ~word_access;
  assign re_o     = ack_q & stb_q & cyc_q & ~we_q & ~word_access;

  uart_wb_lane_mux #(
    .data_width (uart_data_width),
    .addr_width (uart_addr_width)
  ) u_lane_mux (
    .sel         (sel_q),
    .adr         (adr_q),
    .dat_w       (dat_q),
    .dat8_rd     (wb_dat8_o),
    .dat32_rd    (wb_dat32_o),
    .adr_int     (wb_adr_int),
    .dat8_wr     (wb_dat8_i),
    .dat_rd      (wb_dat_o),
    .word_access (word_access)
  );

endmodule

// File: tb/tb_uart_wb.sv
// tb_uart_wb: directed, self-checking bench for uart_wb. Expected transfer
// results are queued when a request is driven and compared when the DUT
// acknowledges it. Handles both the default 32-bit build and the
// UART_DATA_BUS_WIDTH_8_EN build.
module tb_uart_wb;

`ifdef UART_DATA_BUS_WIDTH_8_EN
  localparam int DW = 8;
  localparam int AW = 3;
`else
  localparam int DW = 32;
  localparam int AW = 5;
`endif

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] adr;
    logic [31:0] dat8;
    logic        chk_dat8;
    logic [31:0] dat;
    logic        chk_dat;
  } exp_t;

  logic          clk;
  logic          wb_rst_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_i;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic [3:0]    wb_sel_i;
  logic          wb_ack_o;
  logic [AW-1:0] wb_adr_int;
  logic [7:0]    wb_dat8_i;
  logic [7:0]    wb_dat8_o;
  logic [31:0]   wb_dat32_o;
  logic          we_o;
  logic          re_o;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  uart_wb #(
    .uart_data_width (DW),
    .uart_addr_width (AW)
  ) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_we_i    (wb_we_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_sel_i   (wb_sel_i),
    .wb_ack_o   (wb_ack_o),
    .wb_adr_int (wb_adr_int),
    .wb_dat8_i  (wb_dat8_i),
    .wb_dat8_o  (wb_dat8_o),
    .wb_dat32_o (wb_dat32_o),
    .we_o       (we_o),
    .re_o       (re_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("we_o", 32'(we_o), 32'(e.we));
    check("re_o", 32'(re_o), 32'(e.re));
    check("wb_adr_int", 32'(wb_adr_int), e.adr);
    if (e.chk_dat8) check("wb_dat8_i", 32'(wb_dat8_i), e.dat8);
    if (e.chk_dat) check("wb_dat_o", 32'(wb_dat_o), e.dat);
  endtask

  // Drives one request, queues its expectation, waits (bounded) for the ack,
  // checks it, then releases the bus and checks the ack is a single pulse.
  task automatic applyStimulus(
    input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
    input logic we, input logic [7:0] rd8, input logic [31:0] rd32,
    input logic e_we, input logic e_re, input logic [31:0] e_adr,
    input logic [31:0] e_dat8, input logic chk8,
    input logic [31:0] e_dat, input logic chkd);
    exp_t e;
    bit   seen;
    @(negedge clk);
    wb_adr_i   = AW'(adr);
    wb_sel_i   = sel;
    wb_dat_i   = DW'(dat);
    wb_we_i    = we;
    wb_dat8_o  = rd8;
    wb_dat32_o = rd32;
    wb_stb_i   = 1'b1;
    wb_cyc_i   = 1'b1;
    e.we = e_we; e.re = e_re; e.adr = e_adr;
    e.dat8 = e_dat8; e.chk_dat8 = chk8; e.dat = e_dat; e.chk_dat = chkd;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o === 1'b1) seen = 1'b1;
    end
    check("ack_seen", 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) checkOutput(e);
    @(negedge clk);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    check("ack_pulse", 32'(wb_ack_o), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int ack_count;
    int ack_idx[3];

    vectors     = 0;
    miscompares = 0;
    wb_rst_i    = 1'b0;
    wb_adr_i    = '0;
    wb_dat_i    = '0;
    wb_we_i     = 1'b0;
    wb_stb_i    = 1'b0;
    wb_cyc_i    = 1'b0;
    wb_sel_i    = 4'b0000;
    wb_dat8_o   = 8'h00;
    wb_dat32_o  = 32'h0;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_re", 32'(re_o), 32'd0);
    check("rst_adr_int", 32'(wb_adr_int), 32'd0);
    check("rst_dat8_i", 32'(wb_dat8_i), 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b1;
    repeat (2) @(posedge clk);

`ifdef UART_DATA_BUS_WIDTH_8_EN
    $display("[TB] 8-bit bus build");
    applyStimulus(32'h3, 4'b1111, 32'h80, 1'b1, 8'h00, 32'h0,
                  1'b1, 1'b0, 32'h3, 32'h80, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h5, 4'b0000, 32'h00, 1'b0, 8'h5A, 32'hCAFEF00D,
                  1'b0, 1'b1, 32'h5, 32'h0, 1'b0, 32'h5A, 1'b1);
`else
    $display("[TB] 32-bit bus build");
    // Writes: lane 1, lane 2, malformed select (lane 0), whole word.
    applyStimulus(32'h0C, 4'b0010, 32'h0000A500, 1'b1, 8'h00, 32'h0,
                  1'b1, 1'b0, 32'h0D, 32'hA5, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h10, 4'b0100, 32'h005A0000, 1'b1, 8'h00, 32'h0,
                  1'b1, 1'b0, 32'h12, 32'h5A, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h08, 4'b0011, 32'h12345678, 1'b1, 8'h00, 32'h0,
                  1'b1, 1'b0, 32'h08, 32'h78, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h16, 4'b1111, 32'hFFFFFFFF, 1'b1, 8'h00, 32'h0,
                  1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 1'b0);
    // Reads: lane 3, lane 2, lane 0, whole-word debug read.
    applyStimulus(32'h04, 4'b1000, 32'h0, 1'b0, 8'h3C, 32'h0,
                  1'b0, 1'b1, 32'h07, 32'h0, 1'b0, 32'h3C000000, 1'b1);
    applyStimulus(32'h00, 4'b0100, 32'h0, 1'b0, 8'hC3, 32'h0,
                  1'b0, 1'b1, 32'h02, 32'h0, 1'b0, 32'h00C30000, 1'b1);
    applyStimulus(32'h1F, 4'b0001, 32'h0, 1'b0, 8'h77, 32'h0,
                  1'b0, 1'b1, 32'h1C, 32'h0, 1'b0, 32'h00000077, 1'b1);
    applyStimulus(32'h08, 4'b1111, 32'h0, 1'b0, 8'h55, 32'hDEADBEEF,
                  1'b0, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
`endif

    // Reset asserted in the middle of the ACK cycle.
    @(negedge clk);
    wb_adr_i = AW'(32'h0C);
    wb_sel_i = 4'b0001;
    wb_dat_i = DW'(32'h11);
    wb_we_i  = 1'b1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_ack", 32'(wb_ack_o), 32'd1);
    check("pre_rst_we", 32'(we_o), 32'd1);
    #2;
    wb_rst_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    #1;
    check("mid_rst_ack", 32'(wb_ack_o), 32'd0);
    check("mid_rst_we", 32'(we_o), 32'd0);
    check("mid_rst_re", 32'(re_o), 32'd0);
    check("mid_rst_adr_int", 32'(wb_adr_int), 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b1;
    ack_count = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o === 1'b1) ack_count++;
    end
    check("post_rst_no_ack", 32'(ack_count), 32'd0);

    // Request held for 12 cycles: acks at offsets 0, 4 and 8.
    @(negedge clk);
    wb_adr_i  = '0;
    wb_sel_i  = 4'b0001;
    wb_we_i   = 1'b0;
    wb_dat8_o = 8'h21;
    wb_stb_i  = 1'b1;
    wb_cyc_i  = 1'b1;
    ack_count = 0;
    ack_idx   = '{-1, -1, -1};
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o === 1'b1) begin
        if (ack_count < 3) ack_idx[ack_count] = i;
        ack_count++;
      end
      if (i == 11) begin
        @(negedge clk);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
      end
    end
    check("held_ack_count", 32'(ack_count), 32'd3);
    check("held_first_ack", 32'(ack_idx[0]), 32'd0);
    check("held_gap1", 32'(ack_idx[1] - ack_idx[0]), 32'd4);
    check("held_gap2", 32'(ack_idx[2] - ack_idx[1]), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
